// File: rtl/fifo_rd_arb_pkg.sv
// fifo_rd_arb_pkg: shared state encoding, width helper and reset constants for fifo_read_arbiter.
package fifo_rd_arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam state_t RST_STATE = IDLE;
   function automatic int gw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fifo_read_arbiter_if.sv
// fifo_read_arbiter_if: requester/FIFO-side bundle; the arbiter uses slave, its environment uses master.
interface fifo_read_arbiter_if #(
   parameter int NREQ     = 4,
   parameter int DATASIZE = 8
);
   import fifo_rd_arb_pkg::*;
   localparam int GW = gw(NREQ);
   logic [NREQ-1:0]     req;
   logic                fifo_empty;
   logic [DATASIZE-1:0] fifo_rdata;
   logic                fifo_rd;
   logic [NREQ-1:0]     rsp_valid;
   logic [DATASIZE-1:0] rsp_data;
   logic [GW-1:0]       grant_id;
   logic                busy;
   modport master (output req, fifo_empty, fifo_rdata,
                   input  fifo_rd, rsp_valid, rsp_data, grant_id, busy);
   modport slave  (input  req, fifo_empty, fifo_rdata,
                   output fifo_rd, rsp_valid, rsp_data, grant_id, busy);
endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// rr_pick: combinational cyclic first-set search of req starting at rr_ptr.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int GW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   rr_ptr,
   output logic [GW-1:0]   idx,
   output logic            any
);
   logic [GW-1:0] c;
   // Scan from the farthest offset down so the nearest set bit wins.
   always_comb begin
      idx = '0;
      c = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         c = GW'((int'(rr_ptr) + k) % NREQ);
         if (req[c]) idx = c;
      end
   end
   assign any = |req;
endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin sharing of the async FIFO read port on rclk.
// Define FIFO_RD_ARB_BURST_EN to let a grant pop up to MAXBURST words back-to-back.
module fifo_read_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DATASIZE = 8,
   parameter int MAXBURST = 4
) (
   input logic              rclk,
   input logic              rst_n,
   fifo_read_arbiter_if.slave bus
);
   localparam int GW = gw(NREQ);
   localparam int CW = $clog2(MAXBURST + 1);
`ifdef FIFO_RD_ARB_BURST_EN
   localparam int LIMIT = MAXBURST;
`else
   localparam int LIMIT = 1;
`endif
   state_t              state, state_nx;
   logic [GW-1:0]       rr_ptr, gid, pick_idx;
   logic                pick_any, pop, exit_g, busy;
   logic [CW-1:0]       burst_cnt;
   logic [NREQ-1:0]     rsp_valid_q;
   logic [DATASIZE-1:0] rsp_data_q;

   rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
      .req(bus.req), .rr_ptr(rr_ptr), .idx(pick_idx), .any(pick_any)
   );

   always_ff @(posedge rclk or negedge rst_n)
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nx;

   always_comb
      state_nx = (state == IDLE) ? (pick_any ? GRANT : IDLE) : (exit_g ? IDLE : GRANT);

   // Pops are gated by GRANT, so reset alone silences the read strobe.
   always_comb begin
      busy   = state == GRANT;
      pop    = busy && bus.req[gid] && !bus.fifo_empty;
      exit_g = !bus.req[gid] || (pop && burst_cnt == CW'(LIMIT - 1));
   end

   always_ff @(posedge rclk or negedge rst_n)
      if (!rst_n) begin
         rr_ptr      <= '0;
         gid         <= '0;
         burst_cnt   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= pop ? {{(NREQ-1){1'b0}}, 1'b1} << gid : '0;
         if (pop) rsp_data_q <= bus.fifo_rdata;
         if (state == IDLE && pick_any) gid <= pick_idx;
         if (busy && exit_g) begin
            rr_ptr    <= (gid == GW'(NREQ - 1)) ? '0 : gid + 1'b1;
            burst_cnt <= '0;
         end else if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end

   assign bus.fifo_rd   = pop;
   assign bus.busy      = busy;
   assign bus.grant_id  = gid;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: scoreboard bench with a FIFO model and a transaction-level grant model.
module tb_fifo_read_arbiter;
   localparam int NREQ = 4, DW = 8, MAXBURST = 4;
`ifdef FIFO_RD_ARB_BURST_EN
   localparam int LIMIT = MAXBURST;
`else
   localparam int LIMIT = 1;
`endif
   typedef struct {int id; logic [DW-1:0] data;} exp_t;

   logic rclk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0, errors = 0;
   exp_t exp_q[$];
   logic [DW-1:0] fifo_q[$];
   bit m_granted;
   int m_gid, m_rr, m_cnt;

   fifo_read_arbiter_if #(.NREQ(NREQ), .DATASIZE(DW)) bus();
   fifo_read_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAXBURST(MAXBURST)) dut (
      .rclk(rclk), .rst_n(rst_n), .bus(bus)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic refresh();
      bus.fifo_empty = fifo_q.size() == 0;
      bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      refresh();
   endtask

   function automatic int pick(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) if (r[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return 0;
   endfunction

   // One clock: predict the coming edge from the rules, compare, then let the FIFO react.
   task automatic step();
      bit exp_pop, do_pop;
      exp_t e;
      @(negedge rclk);
      check("busy", bus.busy, m_granted);
      check("grant_id", bus.grant_id, m_gid);
      exp_pop = m_granted && bus.req[m_gid] && fifo_q.size() != 0;
      check("fifo_rd", bus.fifo_rd, exp_pop);
      if (exp_pop) begin
         e.id = m_gid;
         e.data = fifo_q[0];
         exp_q.push_back(e);
      end
      if (!m_granted) begin
         if (|bus.req) begin
            m_gid = pick(bus.req);
            m_granted = 1;
         end
      end else begin
         if (exp_pop) m_cnt++;
         if (!bus.req[m_gid] || m_cnt == LIMIT) begin
            m_granted = 0;
            m_rr = (m_gid + 1) % NREQ;
            m_cnt = 0;
         end
      end
      do_pop = bus.fifo_rd;
      @(posedge rclk);
      #1;
      if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
   endtask

   always @(negedge rclk)
      if (rst_n && bus.rsp_valid != '0) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected got %b want none", bus.rsp_valid);
         end else begin
            e = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, 32'(1) << e.id);
            check("rsp_data", bus.rsp_data, e.data);
         end
      end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fifo_rd"}, bus.fifo_rd, 0);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, "_rsp_data"}, bus.rsp_data, 0);
      check({tag, "_grant_id"}, bus.grant_id, 0);
      check({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      bus.req = '0;
      refresh();
      repeat (2) @(posedge rclk);
      #1 check_reset_outputs("rst");
      @(negedge rclk) rst_n = 1'b1;
      step();
      // Single request with one word queued
      push(8'hA5);
      bus.req = 4'b0100;
      repeat (3) step();
      check("single_gid", bus.grant_id, 2);
      bus.req = '0;
      repeat (2) step();
      // All requesters, eight words
      for (int i = 0; i < 8; i++) push(DW'(i * 17 + 3));
      bus.req = 4'b1111;
      repeat (20) step();
      bus.req = '0;
      repeat (2) step();
      // Grant held across an empty FIFO
      bus.req = 4'b0010;
      repeat (5) step();
      push(8'h3C);
      repeat (3) step();
      bus.req = '0;
      repeat (2) step();
      // Request drops in GRANT just as data arrives
      bus.req = 4'b0001;
      step();
      push(8'h5A);
      bus.req = '0;
      repeat (2) step();
      bus.req = 4'b1111;
      repeat (3) step();
      bus.req = '0;
      repeat (2) step();
      // Single requester with six words
      bus.req = 4'b0001;
      for (int i = 0; i < 6; i++) push(DW'(8'hC0 + i));
      repeat (14) step();
      bus.req = '0;
      repeat (2) step();
      // Randomised traffic
      repeat (400) begin
         if ($urandom_range(2) == 0) push(DW'($urandom));
         if ($urandom_range(3) == 0) bus.req = NREQ'($urandom);
         step();
      end
      bus.req = '0;
      repeat (3) step();
      // Asynchronous reset in the middle of a grant
      for (int i = 0; i < 6; i++) push(DW'(8'h90 + i));
      bus.req = 4'b1111;
      repeat (3) step();
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      bus.req = '0;
      m_granted = 0;
      m_gid = 0;
      m_rr = 0;
      m_cnt = 0;
      exp_q.delete();
      @(posedge rclk);
      @(negedge rclk) rst_n = 1'b1;
      step();
      bus.req = 4'b1111;
      for (int i = 0; i < 100 && fifo_q.size() != 0; i++) step();
      check("fifo_drained", fifo_q.size(), 0);
      bus.req = '0;
      repeat (4) step();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
